// File: rtl/qspi_pkg.sv
// rtl/qspi_pkg.sv - shared QSPI command constants and arbiter state encoding
package qspi_pkg;

    localparam logic [3:0]  SPI_CMD_EOT  = 4'h9;
    // EOT opcode in the top nibble, event bits clear
    localparam logic [31:0] SPI_EOT_WORD = {SPI_CMD_EOT, 28'h000_0000};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        ABORT = 2'd2,
        FLUSH = 2'd3
    } qspi_arb_state_e;

endpackage

// File: rtl/udma_qspi_rr_pick.sv
// rtl/udma_qspi_rr_pick.sv - first set request at or after ptr, searching cyclically
module udma_qspi_rr_pick #(
    parameter int N     = 2,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] idx,
    output logic             found
);

    localparam logic [IDX_W:0] N_L = (IDX_W + 1)'(N);

    logic [IDX_W:0] cand;

    // Walk offsets from the far end so the nearest hit to ptr is written last
    always_comb begin
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = N - 1; k >= 0; k--) begin
            cand = {1'b0, ptr} + (IDX_W + 1)'(k);
            if (cand >= N_L) begin
                cand = cand - N_L;
            end
            if (req[cand[IDX_W-1:0]]) begin
                idx   = cand[IDX_W-1:0];
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/udma_qspi_cmd_arbiter.sv
// rtl/udma_qspi_cmd_arbiter.sv - round-robin, transaction-locked arbiter in front of the QSPI cmd port
module udma_qspi_cmd_arbiter
    import qspi_pkg::*;
#(
    parameter int                NB_REQ   = 2,
    parameter int                DATA_W   = 32,
    parameter int                TMO_W    = 16,
    parameter logic [DATA_W-1:0] EOT_WORD = DATA_W'(SPI_EOT_WORD),
    localparam int               IDX_W    = $clog2(NB_REQ)
) (
    input  logic                     sys_clk_i,
    input  logic                     rst_i,
    input  logic                     clr_i,
    input  logic [TMO_W-1:0]         cfg_timeout_i,
    input  logic [NB_REQ*DATA_W-1:0] req_data_i,
    input  logic [NB_REQ-1:0]        req_valid_i,
    input  logic [NB_REQ-1:0]        req_last_i,
    output logic [NB_REQ-1:0]        req_ready_o,
    output logic [DATA_W-1:0]        cmd_data_o,
    output logic                     cmd_valid_o,
    input  logic                     cmd_ready_i,
    output logic                     busy_o,
    output logic [IDX_W-1:0]         grant_id_o,
    output logic                     abort_evt_o
);

    qspi_arb_state_e   state_q, state_d;
    logic [IDX_W-1:0]  rr_ptr;
    logic [TMO_W-1:0]  tmo_cnt;
    logic [IDX_W-1:0]  pick_idx;
    logic              pick_found;
    logic              grant_valid;
    logic              grant_last;
    logic [DATA_W-1:0] grant_data;
    logic              out_free;
    logic              ready_int;
    logic              accept;
    logic              timeout;
    logic              load_word;
    logic              load_eot;
    logic [IDX_W-1:0]  next_ptr;

    udma_qspi_rr_pick #(
        .N     (NB_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req   (req_valid_i),
        .ptr   (rr_ptr),
        .idx   (pick_idx),
        .found (pick_found)
    );

    assign grant_valid = req_valid_i[grant_id_o];
    assign grant_last  = req_last_i[grant_id_o];
    assign grant_data  = req_data_i[int'(grant_id_o)*DATA_W +: DATA_W];
    assign out_free    = !cmd_valid_o || cmd_ready_i;
    // FLUSH drains the owner regardless of the SPI side; its words are dropped
    assign ready_int   = ((state_q == GRANT) && out_free) || (state_q == FLUSH);
    assign accept      = ready_int && grant_valid;
    assign load_word   = (state_q == GRANT) && accept;
    assign load_eot    = (state_q == ABORT) && out_free;
    assign next_ptr    = (grant_id_o == IDX_W'(NB_REQ - 1)) ? '0 : grant_id_o + 1'b1;
    assign busy_o      = (state_q != IDLE);

    // A stall caused by the SPI master never expires the watchdog
    assign timeout = (state_q == GRANT) && (cfg_timeout_i != '0) &&
                     (tmo_cnt == cfg_timeout_i - 1'b1) && out_free && !accept;

    always_comb begin
        req_ready_o = '0;
        if (ready_int) begin
            req_ready_o[grant_id_o] = 1'b1;
        end
    end

    always_ff @(posedge sys_clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (accept && grant_last) begin
                    state_d = IDLE;
                end else if (timeout) begin
                    state_d = ABORT;
                end
            end
            ABORT: begin
                if (out_free) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                if (accept && grant_last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (clr_i) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge sys_clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_ptr      <= '0;
            grant_id_o  <= '0;
            tmo_cnt     <= '0;
            cmd_data_o  <= '0;
            cmd_valid_o <= 1'b0;
            abort_evt_o <= 1'b0;
        end else if (clr_i) begin
            tmo_cnt     <= '0;
            cmd_data_o  <= '0;
            cmd_valid_o <= 1'b0;
            abort_evt_o <= 1'b0;
        end else begin
            abort_evt_o <= timeout;

            if ((state_q == IDLE) && pick_found) begin
                grant_id_o <= pick_idx;
            end

            if (accept && grant_last) begin
                rr_ptr <= next_ptr;
            end

            if ((state_q != GRANT) || accept) begin
                tmo_cnt <= '0;
            end else if (out_free) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end

            if (load_word) begin
                cmd_data_o  <= grant_data;
                cmd_valid_o <= 1'b1;
            end else if (load_eot) begin
                cmd_data_o  <= EOT_WORD;
                cmd_valid_o <= 1'b1;
            end else if (cmd_ready_i) begin
                cmd_valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_udma_qspi_cmd_arbiter.sv
// tb/tb_udma_qspi_cmd_arbiter.sv - directed self-checking bench for the QSPI cmd arbiter
`timescale 1ns/1ps
module tb_udma_qspi_cmd_arbiter;

    localparam logic [31:0] EOT = 32'h9000_0000;

    logic        sys_clk_i = 1'b0;
    logic        rst_i;
    logic        clr_i;
    logic [15:0] cfg_timeout_i;
    logic [63:0] req_data_i;
    logic [1:0]  req_valid_i;
    logic [1:0]  req_last_i;
    logic [1:0]  req_ready_o;
    logic [31:0] cmd_data_o;
    logic        cmd_valid_o;
    logic        cmd_ready_i;
    logic        busy_o;
    logic [0:0]  grant_id_o;
    logic        abort_evt_o;

    int total = 0;
    int bad   = 0;
    int n_abort = 0;

    logic [32:0] q0[$];
    logic [32:0] q1[$];
    logic [31:0] out_q[$];
    int          owners[$];

    logic        s_cmd_valid;
    logic [31:0] s_cmd_data;
    logic        s_busy;
    logic [0:0]  s_grant;
    logic [1:0]  s_ready;

    udma_qspi_cmd_arbiter #(
        .NB_REQ (2),
        .DATA_W (32),
        .TMO_W  (16)
    ) dut (
        .sys_clk_i     (sys_clk_i),
        .rst_i         (rst_i),
        .clr_i         (clr_i),
        .cfg_timeout_i (cfg_timeout_i),
        .req_data_i    (req_data_i),
        .req_valid_i   (req_valid_i),
        .req_last_i    (req_last_i),
        .req_ready_o   (req_ready_o),
        .cmd_data_o    (cmd_data_o),
        .cmd_valid_o   (cmd_valid_o),
        .cmd_ready_i   (cmd_ready_i),
        .busy_o        (busy_o),
        .grant_id_o    (grant_id_o),
        .abort_evt_o   (abort_evt_o)
    );

    always #5 sys_clk_i = ~sys_clk_i;

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic drive();
        logic [32:0] w;
        req_valid_i = '0;
        req_last_i  = '0;
        req_data_i  = '0;
        if (q0.size() > 0) begin
            w = q0[0];
            req_valid_i[0]    = 1'b1;
            req_last_i[0]     = w[32];
            req_data_i[31:0]  = w[31:0];
        end
        if (q1.size() > 0) begin
            w = q1[0];
            req_valid_i[1]    = 1'b1;
            req_last_i[1]     = w[32];
            req_data_i[63:32] = w[31:0];
        end
    endtask

    task automatic tick();
        logic [1:0] acc;
        drive();
        @(negedge sys_clk_i);
        s_cmd_valid = cmd_valid_o;
        s_cmd_data  = cmd_data_o;
        s_busy      = busy_o;
        s_grant     = grant_id_o;
        s_ready     = req_ready_o;
        if (cmd_valid_o && cmd_ready_i) out_q.push_back(cmd_data_o);
        if (abort_evt_o) n_abort++;
        acc = req_valid_i & req_ready_o;
        for (int i = 0; i < 2; i++) begin
            if (acc[i] && req_last_i[i]) owners.push_back(i);
        end
        @(posedge sys_clk_i);
        #1;
        if (acc[0]) void'(q0.pop_front());
        if (acc[1]) void'(q1.pop_front());
        drive();
    endtask

    task automatic run_until_empty(input int budget, input string name);
        for (int i = 0; i < budget && (q0.size() > 0 || q1.size() > 0); i++) tick();
        total++;
        if (q0.size() > 0 || q1.size() > 0) begin
            bad++;
            $display("FAIL %s_wait: words left q0=%0d q1=%0d, required 0", name, q0.size(), q1.size());
        end
    endtask

    function automatic logic [263:0] pack_q();
        logic [263:0] r;
        r = '0;
        r[263:256] = 8'(out_q.size());
        for (int i = 0; i < out_q.size() && i < 8; i++) r[i*32 +: 32] = out_q[i];
        return r;
    endfunction

    function automatic logic [263:0] stream_of(input int n, input logic [31:0] w0, w1, w2, w3,
                                               input logic [31:0] w4, w5, w6, w7);
        return {8'(n), w7, w6, w5, w4, w3, w2, w1, w0};
    endfunction

    task automatic do_reset();
        rst_i = 1'b1;
        q0.delete();
        q1.delete();
        cmd_ready_i = 1'b1;
        clr_i = 1'b0;
        tick();
        tick();
        rst_i = 1'b0;
        out_q.delete();
        owners.delete();
        n_abort = 0;
    endtask

    task automatic test_reset();
        @(negedge sys_clk_i);
        total++; if (cmd_valid_o !== 1'b0) begin bad++; $display("FAIL rst_cmd_valid: got %b required 0", cmd_valid_o); end
        total++; if (cmd_data_o !== 32'h0) begin bad++; $display("FAIL rst_cmd_data: got %h required 0", cmd_data_o); end
        total++; if (req_ready_o !== 2'b00) begin bad++; $display("FAIL rst_req_ready: got %b required 00", req_ready_o); end
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b required 0", busy_o); end
        total++; if (grant_id_o !== 1'b0) begin bad++; $display("FAIL rst_grant: got %b required 0", grant_id_o); end
        total++; if (abort_evt_o !== 1'b0) begin bad++; $display("FAIL rst_abort: got %b required 0", abort_evt_o); end
    endtask

    task automatic test_single();
        logic [5:0]   vpat;
        logic [1:0]   rdy;
        logic [263:0] got;
        do_reset();
        cfg_timeout_i = 16'd0;
        q0.push_back({1'b0, 32'hA000_0000});
        q0.push_back({1'b0, 32'hA000_0001});
        q0.push_back({1'b1, 32'hA000_0002});
        rdy = 2'b00;
        for (int t = 0; t < 6; t++) begin
            tick();
            vpat[t] = s_cmd_valid;
            if (t == 1) rdy = s_ready;
        end
        total++; if (vpat !== 6'b011100) begin bad++; $display("FAIL single_valid_pattern: got %b required 011100", vpat); end
        total++; if (rdy !== 2'b01) begin bad++; $display("FAIL single_req_ready: got %b required 01", rdy); end
        total++; if (s_busy !== 1'b0) begin bad++; $display("FAIL single_busy_end: got %b required 0", s_busy); end
        got = pack_q();
        total++;
        if (got !== stream_of(3, 32'hA000_0000, 32'hA000_0001, 32'hA000_0002, 0, 0, 0, 0, 0)) begin
            bad++; $display("FAIL single_stream: got %h", got);
        end
        // rr_ptr is now 1: requester 1 must win a simultaneous request
        out_q.delete();
        q0.push_back({1'b1, 32'h0000_00E0});
        q1.push_back({1'b1, 32'h0000_00F0});
        for (int t = 0; t < 10; t++) tick();
        got = pack_q();
        total++;
        if (got !== stream_of(2, 32'h0000_00F0, 32'h0000_00E0, 0, 0, 0, 0, 0, 0)) begin
            bad++; $display("FAIL single_rr_ptr: got %h required F0 then E0", got);
        end
    endtask

    task automatic test_round_robin();
        logic [263:0] got;
        do_reset();
        cfg_timeout_i = 16'd0;
        q0.push_back({1'b0, 32'h10}); q0.push_back({1'b1, 32'h11});
        q0.push_back({1'b0, 32'h12}); q0.push_back({1'b1, 32'h13});
        q1.push_back({1'b0, 32'h20}); q1.push_back({1'b1, 32'h21});
        q1.push_back({1'b0, 32'h22}); q1.push_back({1'b1, 32'h23});
        run_until_empty(60, "rr");
        for (int t = 0; t < 3; t++) tick();
        got = pack_q();
        total++;
        if (got !== stream_of(8, 32'h10, 32'h11, 32'h20, 32'h21, 32'h12, 32'h13, 32'h22, 32'h23)) begin
            bad++; $display("FAIL rr_stream: got %h", got);
        end
        total++;
        if (owners.size() != 4 || owners[0] != 0 || owners[1] != 1 || owners[2] != 0 || owners[3] != 1) begin
            bad++; $display("FAIL rr_owners: got n=%0d, required sequence 0,1,0,1", owners.size());
        end
    endtask

    task automatic test_back_pressure();
        logic [31:0]  held;
        logic         stable;
        logic [263:0] got;
        do_reset();
        cfg_timeout_i = 16'd4;
        q0.push_back({1'b0, 32'h30}); q0.push_back({1'b0, 32'h31});
        q0.push_back({1'b0, 32'h32}); q0.push_back({1'b1, 32'h33});
        for (int t = 0; t < 10 && !s_cmd_valid; t++) tick();
        total++; if (s_cmd_valid !== 1'b1) begin bad++; $display("FAIL bp_first_word: got valid %b required 1", s_cmd_valid); end
        cmd_ready_i = 1'b0;
        tick();
        held = s_cmd_data;
        total++; if (held !== 32'h31) begin bad++; $display("FAIL bp_held_word: got %h required 00000031", held); end
        stable = 1'b1;
        for (int t = 0; t < 9; t++) begin
            tick();
            if (s_cmd_valid !== 1'b1 || s_cmd_data !== 32'h31) stable = 1'b0;
        end
        total++; if (stable !== 1'b1) begin bad++; $display("FAIL bp_stable: got last %h valid %b required 00000031 valid 1", s_cmd_data, s_cmd_valid); end
        cmd_ready_i = 1'b1;
        run_until_empty(20, "bp");
        for (int t = 0; t < 3; t++) tick();
        total++; if (n_abort != 0) begin bad++; $display("FAIL bp_no_abort: got %0d required 0", n_abort); end
        got = pack_q();
        total++;
        if (got !== stream_of(4, 32'h30, 32'h31, 32'h32, 32'h33, 0, 0, 0, 0)) begin
            bad++; $display("FAIL bp_stream: got %h", got);
        end
    endtask

    task automatic test_watchdog();
        logic [263:0] got;
        do_reset();
        cfg_timeout_i = 16'd8;
        q1.push_back({1'b0, 32'h1000_0001});
        run_until_empty(10, "wd_sot");
        for (int t = 0; t < 8; t++) tick();
        total++; if (n_abort != 0) begin bad++; $display("FAIL wd_early_abort: got %0d required 0", n_abort); end
        tick();
        total++; if (n_abort != 1) begin bad++; $display("FAIL wd_abort_pulse: got %0d required 1", n_abort); end
        total++; if (s_grant !== 1'b1) begin bad++; $display("FAIL wd_grant: got %b required 1", s_grant); end
        tick();
        q1.push_back({1'b0, 32'h0000_00B1});
        q1.push_back({1'b1, 32'h0000_00B2});
        for (int t = 0; t < 8; t++) tick();
        total++; if (n_abort != 1) begin bad++; $display("FAIL wd_single_pulse: got %0d required 1", n_abort); end
        total++; if (q1.size() != 0) begin bad++; $display("FAIL wd_flushed: got %0d left required 0", q1.size()); end
        total++; if (s_busy !== 1'b0) begin bad++; $display("FAIL wd_idle: got busy %b required 0", s_busy); end
        got = pack_q();
        total++;
        if (got !== stream_of(2, 32'h1000_0001, EOT, 0, 0, 0, 0, 0, 0)) begin
            bad++; $display("FAIL wd_stream: got %h required SOT then 90000000", got);
        end
    endtask

    task automatic test_accept_vs_timeout();
        logic [263:0] got;
        do_reset();
        cfg_timeout_i = 16'd4;
        q0.push_back({1'b0, 32'h0000_0C00});
        run_until_empty(10, "avt");
        for (int t = 0; t < 3; t++) tick();
        // The next word arrives exactly in the cycle the counter hits its limit
        q0.push_back({1'b1, 32'h0000_0C01});
        for (int t = 0; t < 6; t++) tick();
        total++; if (n_abort != 0) begin bad++; $display("FAIL avt_no_abort: got %0d required 0", n_abort); end
        got = pack_q();
        total++;
        if (got !== stream_of(2, 32'h0000_0C00, 32'h0000_0C01, 0, 0, 0, 0, 0, 0)) begin
            bad++; $display("FAIL avt_stream: got %h", got);
        end
    endtask

    task automatic test_clear_in_flush();
        logic [263:0] got;
        do_reset();
        cfg_timeout_i = 16'd4;
        q0.push_back({1'b1, 32'h0000_0E00});
        for (int t = 0; t < 4; t++) tick();
        q1.push_back({1'b0, 32'h1000_0002});
        run_until_empty(10, "clr_sot");
        tick();
        cmd_ready_i = 1'b0;
        for (int t = 0; t < 5; t++) tick();
        total++; if (s_cmd_valid !== 1'b1 || s_cmd_data !== EOT) begin bad++; $display("FAIL clr_eot_held: got %h valid %b required 90000000 valid 1", s_cmd_data, s_cmd_valid); end
        total++; if (s_busy !== 1'b1) begin bad++; $display("FAIL clr_in_flush: got busy %b required 1", s_busy); end
        clr_i = 1'b1;
        tick();
        clr_i = 1'b0;
        tick();
        total++; if (s_busy !== 1'b0) begin bad++; $display("FAIL clr_idle: got busy %b required 0", s_busy); end
        total++; if (s_cmd_valid !== 1'b0) begin bad++; $display("FAIL clr_cmd_valid: got %b required 0", s_cmd_valid); end
        cmd_ready_i = 1'b1;
        out_q.delete();
        q0.push_back({1'b1, 32'h0000_0E01});
        q1.push_back({1'b1, 32'h0000_0E02});
        for (int t = 0; t < 10; t++) tick();
        got = pack_q();
        total++;
        if (got !== stream_of(2, 32'h0000_0E02, 32'h0000_0E01, 0, 0, 0, 0, 0, 0)) begin
            bad++; $display("FAIL clr_rr_kept: got %h required E02 then E01", got);
        end
    endtask

    task automatic test_no_watchdog();
        logic [263:0] got;
        do_reset();
        cfg_timeout_i = 16'd0;
        q0.push_back({1'b0, 32'h0000_0D00});
        run_until_empty(10, "nowd");
        for (int t = 0; t < 1000; t++) tick();
        total++; if (n_abort != 0) begin bad++; $display("FAIL nowd_abort: got %0d required 0", n_abort); end
        total++; if (s_busy !== 1'b1) begin bad++; $display("FAIL nowd_busy: got %b required 1", s_busy); end
        q0.push_back({1'b1, 32'h0000_0D01});
        for (int t = 0; t < 6; t++) tick();
        got = pack_q();
        total++;
        if (got !== stream_of(2, 32'h0000_0D00, 32'h0000_0D01, 0, 0, 0, 0, 0, 0)) begin
            bad++; $display("FAIL nowd_stream: got %h", got);
        end
    endtask

    task automatic test_async_reset();
        logic [263:0] got;
        do_reset();
        cfg_timeout_i = 16'd0;
        q0.push_back({1'b1, 32'h0000_0F00});
        for (int t = 0; t < 4; t++) tick();
        q1.push_back({1'b0, 32'h0000_0F10});
        q1.push_back({1'b0, 32'h0000_0F11});
        q1.push_back({1'b1, 32'h0000_0F12});
        for (int t = 0; t < 10 && !(s_cmd_valid && s_grant == 1'b1); t++) tick();
        total++; if (s_cmd_valid !== 1'b1 || s_grant !== 1'b1) begin bad++; $display("FAIL ar_setup: got valid %b grant %b required 1 1", s_cmd_valid, s_grant); end
        #2;
        rst_i = 1'b1;
        #1;
        total++; if (cmd_valid_o !== 1'b0) begin bad++; $display("FAIL ar_cmd_valid: got %b required 0", cmd_valid_o); end
        total++; if (cmd_data_o !== 32'h0) begin bad++; $display("FAIL ar_cmd_data: got %h required 0", cmd_data_o); end
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL ar_busy: got %b required 0", busy_o); end
        total++; if (req_ready_o !== 2'b00) begin bad++; $display("FAIL ar_req_ready: got %b required 00", req_ready_o); end
        total++; if (grant_id_o !== 1'b0) begin bad++; $display("FAIL ar_grant: got %b required 0", grant_id_o); end
        q0.delete();
        q1.delete();
        tick();
        tick();
        rst_i = 1'b0;
        out_q.delete();
        q0.push_back({1'b1, 32'h0000_0F20});
        q1.push_back({1'b1, 32'h0000_0F21});
        for (int t = 0; t < 10; t++) tick();
        got = pack_q();
        total++;
        if (got !== stream_of(2, 32'h0000_0F20, 32'h0000_0F21, 0, 0, 0, 0, 0, 0)) begin
            bad++; $display("FAIL ar_rr_from_0: got %h required F20 then F21", got);
        end
    endtask

    initial begin
        rst_i         = 1'b1;
        clr_i         = 1'b0;
        cfg_timeout_i = 16'd0;
        cmd_ready_i   = 1'b1;
        s_cmd_valid   = 1'b0;
        s_cmd_data    = '0;
        s_busy        = 1'b0;
        s_grant       = '0;
        s_ready       = '0;
        drive();
        test_reset();
        test_single();
        test_round_robin();
        test_back_pressure();
        test_watchdog();
        test_accept_vs_timeout();
        test_clear_in_flush();
        test_no_watchdog();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
